canvas_arbiter: RTL and testbench

Single-port arbiter and clear sequencer for the paint canvas cell memory (32×18 cells, 3-bit colour codes). It shares one synchronous RAM port between two requesters: the display read path, which runs at pixel rate, and the mouse draw writer. It also runs a full-canvas clear sweep on reset and on request. It sits between the paint front-end (cursor, palette, draw logic) and the canvas RAM.

---
 rtl/canvas_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_canvas_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_arbiter.sv
// ---------------------------------------------------------------------------
// canvas_arbiter
//
// Shares the single synchronous port of the paint canvas cell memory
// (CELLS_X x CELLS_Y cells, COLOR_W-bit colour codes) between the display
// read path and the mouse draw writer. It also runs a full-canvas clear
// sweep after reset and whenever clear_req_i pulses.
//
// Optional feature macro: CANVAS_CLEAR_BYPASS_EN
//   defined   : display reads are granted during the clear sweep and its
//               done cycle without using the RAM port. They return
//               CLEAR_COLOR one cycle later.
//   undefined : display reads stall (rd_gnt_o=0) until the sweep is done.
//
// Ports
//   clk_100M      in   system clock
//   reset         in   asynchronous, active-high reset
//   clear_req_i   in   one-cycle pulse, starts or restarts the clear sweep
//   draw_req_i    in   write request, held until draw_ack_o
//   draw_addr_i   in   cell to write
//   draw_color_i  in   colour to write
//   draw_ack_o    out  combinational, the draw request is consumed this cycle
//   rd_req_i      in   display read request, held until granted
//   rd_addr_i     in   cell to read
//   rd_gnt_o      out  combinational, the read is granted this cycle
//   rd_valid_o    out  registered, rd_data_o is valid
//   rd_data_o     out  read result
//   mem_we_o      out  RAM write enable
//   mem_addr_o    out  RAM address
//   mem_wdata_o   out  RAM write data
//   mem_rdata_i   in   RAM read data, one cycle after the address
//   busy_o        out  clear sweep in progress
//   clear_done_o  out  one-cycle pulse when the sweep ends
// ---------------------------------------------------------------------------
module canvas_arbiter #(
    parameter int                  CELLS_X     = 32,
    parameter int                  CELLS_Y     = 18,
    parameter int                  ADDR_W      = 10,
    parameter int                  COLOR_W     = 3,
    parameter logic [COLOR_W-1:0]  CLEAR_COLOR = 3'b111
) (
    input  logic               clk_100M,
    input  logic               reset,
    input  logic               clear_req_i,
    input  logic               draw_req_i,
    input  logic [ADDR_W-1:0]  draw_addr_i,
    input  logic [COLOR_W-1:0] draw_color_i,
    output logic               draw_ack_o,
    input  logic               rd_req_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic               rd_gnt_o,
    output logic               rd_valid_o,
    output logic [COLOR_W-1:0] rd_data_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [COLOR_W-1:0] mem_wdata_o,
    input  logic [COLOR_W-1:0] mem_rdata_i,
    output logic               busy_o,
    output logic               clear_done_o
);

    localparam int               CELLS     = CELLS_X * CELLS_Y;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] NUM_CELLS = ADDR_W'(CELLS);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_DONE,
        ST_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last_rd_q, last_rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_from_ram_q, rd_from_ram_d;

    logic grant_ok;
    logic rd_wins;
    logic draw_in_range;
    logic rd_in_range;

    assign draw_in_range = (draw_addr_i < NUM_CELLS);
    assign rd_in_range   = (rd_addr_i < NUM_CELLS);

    // A clear request overrides any pending grant in the same cycle, and
    // nothing is granted while reset is held.
    assign grant_ok = ~clear_req_i & ~reset;

    // State, sweep pointer, arbitration flag and read-return pipeline.
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            ptr_q         <= '0;
            last_rd_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_from_ram_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            last_rd_q     <= last_rd_d;
            rd_valid_q    <= rd_valid_d;
            rd_from_ram_q <= rd_from_ram_d;
        end
    end

    // Next-state logic and RAM port steering. The sweep owns the port in
    // CLEAR; in IDLE the port goes to the single requester, or alternates
    // between them using last_rd when both ask in the same cycle.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        last_rd_d     = last_rd_q;
        rd_from_ram_d = 1'b0;
        rd_wins       = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = CLEAR_COLOR;
        draw_ack_o    = 1'b0;
        rd_gnt_o      = 1'b0;
        busy_o        = 1'b0;
        clear_done_o  = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                busy_o     = 1'b1;
                mem_we_o   = ~reset;
                mem_addr_o = ptr_q;
                if (ptr_q == LAST_CELL) begin
                    state_d = ST_DONE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
`ifdef CANVAS_CLEAR_BYPASS_EN
                rd_gnt_o = rd_req_i & grant_ok;
`endif
            end

            ST_DONE: begin
                clear_done_o = 1'b1;
                state_d      = ST_IDLE;
`ifdef CANVAS_CLEAR_BYPASS_EN
                rd_gnt_o = rd_req_i & grant_ok;
`endif
            end

            ST_IDLE: begin
                rd_wins = rd_req_i & (~draw_req_i | ~last_rd_q);
                if (grant_ok) begin
                    if (rd_wins) begin
                        rd_gnt_o      = 1'b1;
                        mem_addr_o    = rd_addr_i;
                        rd_from_ram_d = rd_in_range;
                    end else if (draw_req_i) begin
                        // Out-of-range draws are consumed but never written.
                        draw_ack_o = 1'b1;
                        if (draw_in_range) begin
                            mem_we_o    = 1'b1;
                            mem_addr_o  = draw_addr_i;
                            mem_wdata_o = draw_color_i;
                        end
                    end
                    if (rd_req_i & draw_req_i) begin
                        last_rd_d = rd_wins;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase

        if (clear_req_i) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end

        rd_valid_d = rd_gnt_o;
    end

    // Bypassed and out-of-range reads return the blank colour instead of RAM.
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_from_ram_q ? mem_rdata_i : CLEAR_COLOR;

endmodule

// File: tb/tb_canvas_arbiter.sv
// ---------------------------------------------------------------------------
// tb_canvas_arbiter
//
// Self-checking bench for canvas_arbiter. A behavioural RAM answers the
// arbiter's port. A cycle-level model tracks the sweep as an age counter,
// the last contested winner and a shadow copy of the canvas, and is compared
// against the DUT on every cycle out of reset. Directed scenarios pin the
// model with hand-computed literal expectations.
// Honours CANVAS_CLEAR_BYPASS_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_canvas_arbiter;

    localparam int CELLS = 576;
    localparam int CLEARC = 7;
`ifdef CANVAS_CLEAR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk_100M = 1'b0;
    logic       reset;
    logic       clear_req;
    logic       draw_req;
    logic [9:0] draw_addr;
    logic [2:0] draw_color;
    logic       draw_ack;
    logic       rd_req;
    logic [9:0] rd_addr;
    logic       rd_gnt;
    logic       rd_valid;
    logic [2:0] rd_data;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;
    logic       busy;
    logic       clear_done;
    logic       ramClear;

    logic [2:0] ram [1024];

    int assertCount = 0;
    int failCount   = 0;

    canvas_arbiter dut (
        .clk_100M     (clk_100M),
        .reset        (reset),
        .clear_req_i  (clear_req),
        .draw_req_i   (draw_req),
        .draw_addr_i  (draw_addr),
        .draw_color_i (draw_color),
        .draw_ack_o   (draw_ack),
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .rd_gnt_o     (rd_gnt),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy),
        .clear_done_o (clear_done)
    );

    // 100 MHz clock.
    always #5 clk_100M = ~clk_100M;

    // Behavioural single-port RAM with one cycle of read latency. It starts
    // filled with zeros so that the sweep and the blank-colour substitution
    // are both observable.
    always @(posedge clk_100M) begin
        if (ramClear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 3'b000;
            mem_rdata <= 3'b000;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle's worth of inputs just after the next rising edge.
    task automatic applyStimulus(input bit clr, input bit dreq, input int daddr, input int dcol,
                                 input bit rreq, input int raddr);
        @(posedge clk_100M);
        #1;
        clear_req  = clr;
        draw_req   = dreq;
        draw_addr  = 10'(daddr);
        draw_color = 3'(dcol);
        rd_req     = rreq;
        rd_addr    = 10'(raddr);
    endtask

    // Model state: mAge counts cycles since the sweep started (0..CELLS-1
    // sweeping, CELLS is the done cycle, beyond that idle).
    int       mAge;
    bit       mLastRd;
    bit       mExpValid;
    int       mExpData;
    bit [2:0] shadow [1024];
    bit       inClr, inDone, eWe, eAck, eGnt, chkAddr, rdSel, rdWins, contested;
    int       eAddr, eWd;

    // Model/compare process: at every falling edge out of reset, derive the
    // outputs the arbiter must show this cycle, compare, then advance the
    // model to the next cycle.
    always @(negedge clk_100M) begin
        if (reset) begin
            mAge      = 0;
            mLastRd   = 1'b0;
            mExpValid = 1'b0;
            mExpData  = CLEARC;
        end else begin
            inClr     = (mAge < CELLS);
            inDone    = (mAge == CELLS);
            eWe       = 1'b0;
            eAddr     = 0;
            eWd       = 0;
            eAck      = 1'b0;
            eGnt      = 1'b0;
            chkAddr   = 1'b1;
            rdSel     = 1'b0;
            rdWins    = 1'b0;
            contested = 1'b0;
            if (inClr) begin
                eWe   = 1'b1;
                eAddr = mAge;
                eWd   = CLEARC;
            end
            if (!clear_req) begin
                if (inClr || inDone) begin
                    eGnt = BYPASS && rd_req;
                end else begin
                    rdWins    = rd_req && (!draw_req || !mLastRd);
                    contested = rd_req && draw_req;
                    if (rdWins) begin
                        eGnt  = 1'b1;
                        eAddr = int'(rd_addr);
                        rdSel = 1'b1;
                    end else if (draw_req) begin
                        eAck = 1'b1;
                        if (int'(draw_addr) < CELLS) begin
                            eWe   = 1'b1;
                            eAddr = int'(draw_addr);
                            eWd   = int'(draw_color);
                        end else begin
                            chkAddr = 1'b0;
                        end
                    end
                end
            end

            checkOutput("cmp_busy", busy, inClr);
            checkOutput("cmp_clear_done", clear_done, inDone);
            checkOutput("cmp_draw_ack", draw_ack, eAck);
            checkOutput("cmp_rd_gnt", rd_gnt, eGnt);
            checkOutput("cmp_mem_we", mem_we, eWe);
            if (chkAddr) checkOutput("cmp_mem_addr", mem_addr, eAddr);
            if (eWe) checkOutput("cmp_mem_wdata", mem_wdata, eWd);
            checkOutput("cmp_rd_valid", rd_valid, mExpValid);
            if (mExpValid) checkOutput("cmp_rd_data", rd_data, mExpData);

            mExpValid = eGnt;
            mExpData  = (rdSel && int'(rd_addr) < CELLS) ? int'(shadow[rd_addr]) : CLEARC;
            if (eWe) shadow[eAddr] = 3'(eWd);
            if (contested) mLastRd = rdWins;
            if (clear_req) mAge = 0;
            else if (mAge <= CELLS) mAge++;
        end
    end

    int       weCnt, firstWe, lastWe, doneCnt, doneAt, busyFall;
    int       ackCnt, k, doneK, gntK, validK, validData;
    bit       reqOn;
    bit [5:0] pat;

    // Directed scenarios with literal expectations.
    initial begin
        reset      = 1'b1;
        ramClear   = 1'b1;
        clear_req  = 1'b0;
        draw_req   = 1'b0;
        draw_addr  = '0;
        draw_color = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        repeat (3) @(posedge clk_100M);
        #1 ramClear = 1'b0;

        // Values held while in reset.
        @(negedge clk_100M);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_clear_done", clear_done, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 7);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);

        // Power-up sweep: 576 writes, then one done cycle.
        @(posedge clk_100M);
        #1 reset = 1'b0;
        weCnt = 0; firstWe = -1; lastWe = -1; doneCnt = 0; doneAt = -1; busyFall = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_100M);
            if (mem_we) begin
                weCnt++;
                if (firstWe < 0) firstWe = i;
                lastWe = i;
            end
            if (clear_done) begin
                doneCnt++;
                doneAt = i;
            end
            if (!busy && busyFall < 0) busyFall = i;
        end
        checkOutput("sweep_we_count", weCnt, 576);
        checkOutput("sweep_first_we", firstWe, 0);
        checkOutput("sweep_last_we", lastWe, 575);
        checkOutput("sweep_done_count", doneCnt, 1);
        checkOutput("sweep_done_cycle", doneAt, 576);
        checkOutput("sweep_busy_fall", busyFall, 576);

        // Single draw to cell 37, then read it back.
        applyStimulus(0, 1, 37, 2, 0, 0);
        @(negedge clk_100M);
        checkOutput("draw37_ack", draw_ack, 1);
        checkOutput("draw37_we", mem_we, 1);
        checkOutput("draw37_addr", mem_addr, 37);
        applyStimulus(0, 0, 0, 0, 1, 37);
        @(negedge clk_100M);
        checkOutput("read37_gnt", rd_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        checkOutput("read37_valid", rd_valid, 1);
        checkOutput("read37_data", rd_data, 2);

        // Both requesters held for six cycles: R,W,R,W,R,W.
        applyStimulus(0, 1, 100, 5, 1, 37);
        ackCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_100M);
            pat[i] = rd_gnt;
            ackCnt += int'(draw_ack);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("alt_pattern", pat, 6'b010101);
        checkOutput("alt_acks", ackCnt, 3);

        // Out-of-range draw is consumed but not written.
        applyStimulus(0, 1, 600, 3, 0, 0);
        @(negedge clk_100M);
        checkOutput("oor_draw_ack", draw_ack, 1);
        checkOutput("oor_draw_we", mem_we, 0);
        // Out-of-range read returns the blank colour.
        applyStimulus(0, 0, 0, 0, 1, 700);
        @(negedge clk_100M);
        checkOutput("oor_read_gnt", rd_gnt, 1);
        applyStimulus(0, 0, 0, 0, 1, 100);
        @(negedge clk_100M);
        checkOutput("oor_read_valid", rd_valid, 1);
        checkOutput("oor_read_data", rd_data, 7);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        checkOutput("read100_data", rd_data, 5);

        // Clear request from IDLE, restarted at ptr 200.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        checkOutput("clr_pulse_busy", busy, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        checkOutput("clr_first_addr", mem_addr, 0);
        repeat (199) @(negedge clk_100M);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        checkOutput("restart_at_addr", mem_addr, 200);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_100M);
        checkOutput("restart_next_addr", mem_addr, 0);

        // Count to clear_done while a read of cell 5 is raised during the
        // sweep, with a bounded cycle budget.
        k = 1; doneK = -1; gntK = -1; validK = -1; validData = -1; reqOn = 1'b0;
        while (k < 1000 && (doneK < 0 || validK < 0)) begin
            if (clear_done && doneK < 0) doneK = k;
            if (rd_valid && gntK >= 0 && validK < 0) begin
                validK    = k;
                validData = int'(rd_data);
            end
            if (reqOn && rd_gnt && gntK < 0) gntK = k;
            @(posedge clk_100M);
            #1;
            if (k == 9) begin
                rd_req  = 1'b1;
                rd_addr = 10'd5;
                reqOn   = 1'b1;
            end
            if (gntK >= 0) rd_req = 1'b0;
            @(negedge clk_100M);
            k++;
        end
        checkOutput("restart_done_delay", doneK, 577);
        checkOutput("clear_read_gnt_cycle", gntK, BYPASS ? 10 : 578);
        checkOutput("clear_read_valid_cycle", validK, gntK + 1);
        checkOutput("clear_read_data", validData, 7);

        // last_rd survives uncontested cycles: next contest is R then W.
        applyStimulus(0, 1, 200, 6, 1, 37);
        @(negedge clk_100M);
        checkOutput("contest2_first_rd", rd_gnt, 1);
        @(negedge clk_100M);
        checkOutput("contest2_second_ack", draw_ack, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Asynchronous reset while a read is returning.
        applyStimulus(0, 0, 0, 0, 1, 37);
        @(negedge clk_100M);
        checkOutput("pre_reset_gnt", rd_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("pre_reset_valid", rd_valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", rd_valid, 0);
        checkOutput("async_reset_busy", busy, 1);
        checkOutput("async_reset_we", mem_we, 0);
        @(posedge clk_100M);
        #1 reset = 1'b0;
        @(negedge clk_100M);
        checkOutput("resweep_addr0", mem_addr, 0);
        checkOutput("resweep_we", mem_we, 1);
        @(negedge clk_100M);
        checkOutput("resweep_addr1", mem_addr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
